// File: rtl/reg_arb_pkg.sv
// ----------------------------------------------------------------------------
// reg_arb_pkg
// Shared types and constants for the register write arbiter.
//   arb_state_e : arbiter state (idle round-robin vs. locked to one owner)
//   GrantCntW   : width of the accepted-write statistics counter
//   BeatW       : width of the locked-burst beat counter (MAX_BURST <= 255)
// ----------------------------------------------------------------------------
package reg_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } arb_state_e;

    localparam int unsigned GrantCntW = 16;
    localparam int unsigned BeatW     = 8;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin first-one finder. Searches valid_i upward starting
// at ptr_i, wrapping from NREQ-1 back to 0, and reports the first set bit.
// Ports:
//   valid_i [NREQ-1:0]  request vector
//   ptr_i   [IdxW-1:0]  search start position (must be < NREQ)
//   idx_o   [IdxW-1:0]  index of the winner (0 when none found)
//   found_o             at least one bit of valid_i is set
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         valid_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    found_o
);

    localparam int unsigned IdxW = $clog2(NREQ);

    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;
    logic            hit;

    always_comb begin
        idx_o    = '0;
        hit      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand     = (32'(ptr_i) + k) % NREQ;
            cand_idx = IdxW'(cand);
            // Only the first hit in search order is kept.
            if (!hit && valid_i[cand_idx]) begin
                hit   = 1'b1;
                idx_o = cand_idx;
            end
        end
        found_o = hit;
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// ----------------------------------------------------------------------------
// reg_write_arbiter
// Arbitrates NREQ write requesters onto one shared N-bit register. In idle
// the grant rotates round-robin; a requester holding req_lock keeps the grant
// for up to MAX_BURST beats. The register itself lives outside this block:
// reg_d is fed to its input and reg_q is its current output.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   req_valid    [NREQ]    per-requester write request
//   req_lock     [NREQ]    per-requester request to keep the grant
//   req_data     [NREQ*N]  packed write data, requester i at [i*N +: N]
//   req_ready    [NREQ]    one-hot-or-zero write accept
//   reg_q        [N]       shared register output
//   reg_d        [N]       shared register next value
//   grant_id     [clog2]   current or most recent winner
//   locked                 high while a burst holds the grant
//   grant_count  [16]      accepted writes, saturating
//
// Optional feature: define REG_ARB_STATS_EN to build the grant_count
// counter; otherwise grant_count is constant zero and no flops exist for it.
// ----------------------------------------------------------------------------
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned N         = 32,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_lock,
    input  logic [NREQ*N-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic [N-1:0]            reg_q,
    output logic [N-1:0]            reg_d,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    locked,
    output logic [GrantCntW-1:0]    grant_count
);

    localparam int unsigned IdxW = $clog2(NREQ);

    arb_state_e       state_q;
    logic [IdxW-1:0]  ptr_q;
    logic [IdxW-1:0]  grant_id_q;  // doubles as burst owner while locked
    logic [BeatW-1:0] beat_q;

    logic [IdxW-1:0]  pick_idx;
    logic             pick_found;
    logic [IdxW-1:0]  sel_idx;
    logic [IdxW-1:0]  sel_next;
    logic             xfer;
    logic             lock_hold;
    logic             burst_done;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Grant selection and datapath. Reset gates the accept directly so that
    // ready drops and reg_d holds without waiting for a clock edge.
    always_comb begin
        sel_idx = pick_idx;
        xfer    = 1'b0;
        if (!rst) begin
            if (state_q == StLocked) begin
                sel_idx = grant_id_q;
                xfer    = req_valid[grant_id_q];
            end else begin
                xfer = pick_found;
            end
        end

        req_ready = '0;
        if (xfer) begin
            req_ready[sel_idx] = 1'b1;
        end

        reg_d = xfer ? req_data[sel_idx*N +: N] : reg_q;

        sel_next   = (sel_idx == IdxW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
        lock_hold  = req_lock[sel_idx];
        // Beat that would bring the count to MAX_BURST ends the burst.
        burst_done = ((beat_q + 1'b1) >= BeatW'(MAX_BURST));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            grant_id_q <= '0;
            beat_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (xfer) begin
                        ptr_q      <= sel_next;
                        grant_id_q <= sel_idx;
                        if (lock_hold && (MAX_BURST > 1)) begin
                            state_q <= StLocked;
                            beat_q  <= BeatW'(1);
                        end
                    end
                end
                StLocked: begin
                    if (xfer) begin
                        if (!lock_hold || burst_done) begin
                            state_q <= StIdle;
                            beat_q  <= '0;
                            ptr_q   <= sel_next;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end else begin
                        // Owner went quiet: give the bus back.
                        state_q <= StIdle;
                        beat_q  <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    beat_q  <= '0;
                end
            endcase
        end
    end

    assign grant_id = grant_id_q;
    assign locked   = (state_q == StLocked);

`ifdef REG_ARB_STATS_EN
    logic [GrantCntW-1:0] grant_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_count_q <= '0;
        end else if (xfer && (grant_count_q != {GrantCntW{1'b1}})) begin
            grant_count_q <= grant_count_q + 1'b1;
        end
    end

    assign grant_count = grant_count_q;
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_reg_write_arbiter
// Self-checking bench for reg_write_arbiter (NREQ=4, N=32, MAX_BURST=8).
// Directed scenarios plus a randomized run against a behavioural model of
// the arbitration rules. The shared register is modelled by a plain flop.
// ----------------------------------------------------------------------------
module tb_reg_write_arbiter;

    localparam int unsigned N         = 32;
    localparam int unsigned NREQ      = 4;
    localparam int unsigned MAX_BURST = 8;
    localparam int unsigned IdxW      = $clog2(NREQ);
`ifdef REG_ARB_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_lock;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [N-1:0]      reg_q = '0;
    logic [N-1:0]      reg_d;
    logic [IdxW-1:0]   grant_id;
    logic              locked;
    logic [15:0]       grant_count;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int          m_ptr, m_owner, m_beats, m_gid, m_count;
    bit          m_locked;
    logic [N-1:0] m_reg = '0;

    always #5 clk = ~clk;

    // External shared register
    always @(posedge clk) reg_q <= reg_d;

    reg_write_arbiter #(
        .N         (N),
        .NREQ      (NREQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_lock    (req_lock),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .reg_q       (reg_q),
        .reg_d       (reg_d),
        .grant_id    (grant_id),
        .locked      (locked),
        .grant_count (grant_count)
    );

    function automatic logic [NREQ*N-1:0] rand_data();
        logic [NREQ*N-1:0] d;
        for (int i = 0; i < NREQ; i++) d[i*N +: N] = $urandom;
        return d;
    endfunction

    // Winning requester for the given valid vector, -1 if nobody wins.
    function automatic int m_winner(input logic [NREQ-1:0] v);
        if (m_locked) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] m_ready(input logic [NREQ-1:0] v);
        logic [NREQ-1:0] r;
        int w;
        r = '0;
        w = m_winner(v);
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic m_reset();
        m_ptr = 0; m_owner = 0; m_beats = 0; m_gid = 0; m_count = 0; m_locked = 0;
    endtask

    task automatic m_advance();
        int w;
        w = m_winner(req_valid);
        if (w >= 0) begin
            m_reg = req_data[w*N +: N];
            if (StatsEn && m_count < 65535) m_count++;
            if (!m_locked) begin
                m_ptr = (w + 1) % NREQ;
                m_gid = w;
                if (req_lock[w] && MAX_BURST > 1) begin
                    m_locked = 1; m_owner = w; m_beats = 1;
                end
            end else begin
                m_beats++;
                if (!req_lock[w] || m_beats >= MAX_BURST) begin
                    m_locked = 0;
                    m_ptr    = (m_owner + 1) % NREQ;
                end
            end
        end else if (m_locked) begin
            m_locked = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_advance();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; req_lock = '1; req_data = rand_data();
        m_reset();
        #2;
        vectors++;
        if (req_ready !== '0) begin
            miscompares++; $display("FAIL reset_ready: got %b want 0", req_ready);
        end
        vectors++;
        if (locked !== 1'b0 || grant_id !== '0) begin
            miscompares++; $display("FAIL reset_state: got locked=%b id=%0d want 0/0", locked, grant_id);
        end
        vectors++;
        if (grant_count !== 16'h0) begin
            miscompares++; $display("FAIL reset_count: got %h want 0", grant_count);
        end
        vectors++;
        if (reg_d !== m_reg) begin
            miscompares++; $display("FAIL reset_hold: got %h want %h", reg_d, m_reg);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; req_valid = '0; req_lock = '0;
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp;
        logic [N-1:0]    want;
        for (int k = 0; k < 8; k++) begin
            req_valid = '1; req_lock = '0; req_data = rand_data();
            exp = '0; exp[k % NREQ] = 1'b1;
            want = req_data[(k % NREQ)*N +: N];
            @(negedge clk);
            vectors++;
            if (req_ready !== exp) begin
                miscompares++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp);
            end
            vectors++;
            if (reg_d !== want) begin
                miscompares++; $display("FAIL rr_reg_d[%0d]: got %h want %h", k, reg_d, want);
            end
            tick();
            vectors++;
            if (reg_q !== want || grant_id !== IdxW'(k % NREQ)) begin
                miscompares++;
                $display("FAIL rr_write[%0d]: got q=%h id=%0d want q=%h id=%0d",
                         k, reg_q, grant_id, want, k % NREQ);
            end
        end
    endtask

    task automatic test_wrap();
        logic [NREQ-1:0] exp [3];
        exp[0] = 4'b0001; exp[1] = 4'b0100; exp[2] = 4'b0001;
        // Grant requester 2 alone so the pointer lands on 3.
        req_valid = 4'b0100; req_lock = '0; req_data = rand_data();
        tick();
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'b0101; req_data = rand_data();
            @(negedge clk);
            vectors++;
            if (req_ready !== exp[k]) begin
                miscompares++; $display("FAIL wrap_ready[%0d]: got %b want %b", k, req_ready, exp[k]);
            end
            tick();
        end
    endtask

    task automatic test_burst_cap();
        // Put the pointer on 2 by granting requester 1 alone.
        req_valid = 4'b0010; req_lock = '0; req_data = rand_data();
        tick();
        for (int k = 0; k <= MAX_BURST; k++) begin
            req_valid = 4'b0110; req_lock = 4'b0100; req_data = rand_data();
            @(negedge clk);
            vectors++;
            if (k < MAX_BURST) begin
                if (req_ready !== 4'b0100 || locked !== (k != 0)) begin
                    miscompares++;
                    $display("FAIL burst_beat[%0d]: got rdy=%b lk=%b want rdy=0100 lk=%b",
                             k, req_ready, locked, k != 0);
                end
            end else begin
                if (req_ready !== 4'b0010 || locked !== 1'b0) begin
                    miscompares++;
                    $display("FAIL burst_release: got rdy=%b lk=%b want rdy=0010 lk=0",
                             req_ready, locked);
                end
            end
            tick();
        end
    endtask

    task automatic test_lock_drop();
        logic [N-1:0] held;
        req_valid = 4'b0010; req_lock = 4'b0010; req_data = rand_data();
        tick();
        held = req_data[1*N +: N];
        req_valid = 4'b1000; req_lock = '0; req_data = rand_data();
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0000 || locked !== 1'b1 || reg_d !== held) begin
            miscompares++;
            $display("FAIL drop_gap: got rdy=%b lk=%b d=%h want rdy=0000 lk=1 d=%h",
                     req_ready, locked, reg_d, held);
        end
        tick();
        vectors++;
        if (reg_q !== held) begin
            miscompares++; $display("FAIL drop_hold: got %h want %h", reg_q, held);
        end
        @(negedge clk);
        vectors++;
        if (locked !== 1'b0 || req_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL drop_next: got lk=%b rdy=%b want lk=0 rdy=1000", locked, req_ready);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        req_valid = 4'b0100; req_lock = 4'b0100; req_data = rand_data();
        tick(); tick(); tick();
        #1;
        rst = 1'b1;
        m_reset();
        #1;
        vectors++;
        if (req_ready !== '0 || locked !== 1'b0 || grant_count !== 16'h0 || grant_id !== '0) begin
            miscompares++;
            $display("FAIL midrst_async: got rdy=%b lk=%b cnt=%h id=%0d want all 0",
                     req_ready, locked, grant_count, grant_id);
        end
        vectors++;
        if (reg_d !== m_reg) begin
            miscompares++; $display("FAIL midrst_hold: got %h want %h", reg_d, m_reg);
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '1; req_lock = '0; req_data = rand_data();
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL midrst_first: got %b want 0001", req_ready);
        end
        tick();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] exp_rdy;
        logic [N-1:0]    exp_d;
        int w;
        for (int i = 0; i < 300; i++) begin
            req_valid = NREQ'($urandom);
            req_lock  = NREQ'($urandom) | NREQ'($urandom);
            req_data  = rand_data();
            w       = m_winner(req_valid);
            exp_rdy = m_ready(req_valid);
            exp_d   = (w < 0) ? m_reg : req_data[w*N +: N];
            @(negedge clk);
            vectors++;
            if (req_ready !== exp_rdy || reg_d !== exp_d) begin
                miscompares++;
                $display("FAIL rand_out[%0d]: got rdy=%b d=%h want rdy=%b d=%h",
                         i, req_ready, reg_d, exp_rdy, exp_d);
            end
            vectors++;
            if (locked !== m_locked || grant_id !== IdxW'(m_gid) || grant_count !== 16'(m_count)) begin
                miscompares++;
                $display("FAIL rand_state[%0d]: got lk=%b id=%0d cnt=%0d want lk=%b id=%0d cnt=%0d",
                         i, locked, grant_id, grant_count, m_locked, m_gid, m_count);
            end
            tick();
            vectors++;
            if (reg_q !== m_reg) begin
                miscompares++; $display("FAIL rand_reg[%0d]: got %h want %h", i, reg_q, m_reg);
            end
        end
    endtask

    task automatic test_stats();
        req_valid = '1; req_lock = '0; req_data = rand_data();
`ifdef REG_ARB_STATS_EN
        repeat (70000) tick();
        @(negedge clk);
        vectors++;
        if (grant_count !== 16'hFFFF) begin
            miscompares++; $display("FAIL stats_sat: got %h want ffff", grant_count);
        end
`else
        repeat (16) tick();
        @(negedge clk);
        vectors++;
        if (grant_count !== 16'h0) begin
            miscompares++; $display("FAIL stats_off: got %h want 0", grant_count);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wrap();
        test_burst_cap();
        test_lock_drop();
        test_reset_mid_burst();
        test_random();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter N, default 32, data width of the shared Nbit_Register.
REQ-002 Parameter NREQ, default 4, number of write requesters (2..8).
REQ-003 Parameter MAX_BURST, default 8, maximum beats per locked burst (1..255).
REQ-004 Port clk, input, 1, single rising-edge clock for all state.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port req_valid, input, NREQ, per-requester write request.
REQ-007 Port req_lock, input, NREQ, per-requester request to hold the grant after this beat.
REQ-008 Port req_data, input, NREQ*N, packed write data; requester i occupies bits [i*N +: N].
REQ-009 Port req_ready, output, NREQ, one-hot-or-zero write accept.
REQ-010 Port reg_q, input, N, current output of the shared register.
REQ-011 Port reg_d, output, N, next value driven to the register's ino.
REQ-012 Port grant_id, output, clog2(NREQ), index of the current or most recent winner.
REQ-013 Port locked, output, 1, high while in LOCKED state.
REQ-014 Port grant_count, output, 16, accepted-write counter (see Configuration).

Function
REQ-015 Transfer on requester i occurs in a cycle when req_valid[i] and req_ready[i] are both high.
REQ-016 req_ready is combinational from registered state and req_valid; at most one bit high per cycle.
REQ-017 reg_d = winning req_data in a transfer cycle, else reg_q (hold); register updates at the next edge (1-cycle write latency).
REQ-018 States: IDLE (round-robin arbitration), LOCKED (grant held by owner).
REQ-019 IDLE: winner = first valid requester searching upward from ptr, wrapping NREQ-1 -> 0; no valid -> no ready.
REQ-020 After any IDLE transfer by requester w, ptr <= (w+1) mod NREQ; grant_id <= w.
REQ-021 IDLE transfer with req_lock[w] high and MAX_BURST > 1 -> LOCKED, owner = w, beat count = 1.
REQ-022 LOCKED: only the owner may receive ready; other requesters see ready low.
REQ-023 LOCKED transfer with req_lock low -> IDLE; with req_lock high, beat count increments.
REQ-024 LOCKED transfer that brings beat count to MAX_BURST -> IDLE regardless of req_lock (forced release).
REQ-025 LOCKED with owner req_valid low -> no transfer, IDLE next cycle.
REQ-026 ptr advances only on transfers; in LOCKED it is (owner+1) mod NREQ upon release.
REQ-027 Inputs of non-granted requesters are ignored; no requester is dropped while it holds valid (no starvation beyond NREQ-1 bursts).

Reset
REQ-028 rst high forces state IDLE, ptr 0, grant_id 0, beat count 0, locked 0, grant_count 0 immediately, independent of clk.
REQ-029 During rst req_ready is all zeros and reg_d = reg_q; a burst in progress at reset is abandoned.
REQ-030 First arbitration after rst deassertion starts at requester 0.

Configuration
REQ-031 Macro REG_ARB_STATS_EN defined: grant_count increments by 1 per transfer, saturating at 16'hFFFF.
REQ-032 Macro REG_ARB_STATS_EN undefined: grant_count tied to 0, no counter flops synthesised.

Structure
REQ-033 Shared package reg_arb_pkg holds the state enumeration (IDLE, LOCKED) and the grant_count width constant (16).
REQ-034 Sub-module rr_pick (combinational round-robin first-one finder, inputs valid vector and ptr, outputs winner index and found flag) is instantiated once.
REQ-035 The shared register itself (Nbit_Register) is instantiated outside this block.

Verification
REQ-036 Reset: rst pulsed mid-burst -> req_ready=0, locked=0, grant_count=0 asynchronously; next grant goes to requester 0.
REQ-037 Round-robin: req_valid=4'b1111 held, lock=0 for 8 cycles -> grants 0,1,2,3,0,1,2,3; reg_q tracks each req_data one cycle later.
REQ-038 Wrap: ptr=3, req_valid=4'b0101 -> grant 0, then 2, then 0.
REQ-039 Burst cap: MAX_BURST=8, requester 2 valid+lock held, requester 1 valid -> 8 beats to 2, then requester 1 granted, locked low.
REQ-040 Lock drop: owner 1 locked, deasserts valid for one cycle -> no write (reg_q unchanged), IDLE next cycle, requester 3 may win.
REQ-041 Stats: with REG_ARB_STATS_EN, 70000 transfers -> grant_count = 16'hFFFF; without the macro it reads 0.
